// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller.
//   sw_state_e : controller FSM states
//   TIME_W     : width of the packed BCD time word
//   *_W        : widths of the fields inside the time word
//                {min2, min1, sec2, sec1, pt2, pt1}
package stopwatch_pkg;

  localparam int TIME_W = 23;

  localparam int MIN2_W = 4;
  localparam int MIN1_W = 4;
  localparam int SEC2_W = 4;
  localparam int SEC1_W = 4;
  localparam int PT2_W  = 3;
  localparam int PT1_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_LAP   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_CLEAR = 3'd4
  } sw_state_e;

  // The timer advances in both RUN and LAP; LAP only freezes the display.
  function automatic logic is_counting(input sw_state_e s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// btn_debounce: synchronizes a raw asynchronous button, debounces it and
// emits a one-clk press pulse on the accepted rising edge.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_raw    : raw button level, active-high, asynchronous
//   press      : one-clk pulse when the debounced level goes 0 -> 1
// The debounced level only flips after DEBOUNCE_CYCLES consecutive
// synchronized samples that differ from it; any sample equal to the
// current level restarts the count. Releases are accepted silently.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // This sample completes the run of differing samples.
      cnt_d   = '0;
      level_d = sync2_q;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop and lap/reset control for a BCD stopwatch timer.
//   clk, rst_n   : clock, asynchronous active-low reset
//   vga_clk_en   : one-cycle enable strobe shared with the timer
//   btn_ss       : raw start/stop button
//   btn_lr       : raw lap/reset button
//   i_time       : live packed BCD time from the timer
//   cnt_up_pls   : count-up request to the timer (only ever with vga_clk_en)
//   tmr_rst_n    : registered active-low clear to the timer (2 clk in CLEAR)
//   o_disp_time  : lap snapshot while in LAP, otherwise the live time
//   o_running    : RUN or LAP
//   o_lap        : LAP
//   o_state      : current FSM state, for observation
// When both buttons are accepted in the same cycle, start/stop wins.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int PRESCALE        = 1,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vga_clk_en,
  input  logic              btn_ss,
  input  logic              btn_lr,
  input  logic [TIME_W-1:0] i_time,
  output logic              cnt_up_pls,
  output logic              tmr_rst_n,
  output logic [TIME_W-1:0] o_disp_time,
  output logic              o_running,
  output logic              o_lap,
  output sw_state_e         o_state
);

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  logic ss_press;
  logic lr_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_ss (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_ss),
    .press   (ss_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_lr (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_lr),
    .press   (lr_press)
  );

  sw_state_e         state_q, state_d;
  logic [15:0]       presc_q, presc_d;
  logic [TIME_W-1:0] lap_q, lap_d;
  logic              clr_cnt_q, clr_cnt_d;
  logic              tmr_rst_n_q, tmr_rst_n_d;
  logic              running_q, running_d;
  logic              lap_flag_q, lap_flag_d;
  logic              tick;

  assign tick = is_counting(state_q) && vga_clk_en && (presc_q == PRESC_LAST);

  always_comb begin
    state_d   = state_q;
    lap_d     = lap_q;
    clr_cnt_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ss_press) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ss_press) begin
          state_d = ST_PAUSE;
        end else if (lr_press) begin
          state_d = ST_LAP;
          lap_d   = i_time;
        end
      end
      ST_LAP: begin
        if (ss_press)      state_d = ST_PAUSE;
        else if (lr_press) state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (ss_press)      state_d = ST_RUN;
        else if (lr_press) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        // Two cycles in CLEAR; button presses are ignored here.
        if (clr_cnt_q) state_d = ST_IDLE;
        else           clr_cnt_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Prescaler runs only while counting, holds through PAUSE so a resume
    // continues the partial period, and restarts from zero otherwise.
    presc_d = presc_q;
    if (is_counting(state_q)) begin
      if (vga_clk_en) presc_d = tick ? 16'd0 : presc_q + 16'd1;
    end else if (state_q != ST_PAUSE) begin
      presc_d = 16'd0;
    end

    // Status outputs are registered from the next state so they line up
    // with state_q.
    tmr_rst_n_d = (state_d != ST_CLEAR);
    running_d   = is_counting(state_d);
    lap_flag_d  = (state_d == ST_LAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      presc_q     <= 16'd0;
      lap_q       <= '0;
      clr_cnt_q   <= 1'b0;
      tmr_rst_n_q <= 1'b1;
      running_q   <= 1'b0;
      lap_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      lap_q       <= lap_d;
      clr_cnt_q   <= clr_cnt_d;
      tmr_rst_n_q <= tmr_rst_n_d;
      running_q   <= running_d;
      lap_flag_q  <= lap_flag_d;
    end
  end

  assign cnt_up_pls  = tick;
  assign tmr_rst_n   = tmr_rst_n_q;
  assign o_disp_time = (state_q == ST_LAP) ? lap_q : i_time;
  assign o_running   = running_q;
  assign o_lap       = lap_flag_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with PRESCALE=4, DEBOUNCE_CYCLES=8 and a strobe
// every 4th clk. A behavioural timer (tick count -> BCD) drives i_time; the
// reference model tracks the mode per accepted press and counts strobes
// spent counting, so expected timer value = counting strobes / PRESCALE.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int PRESCALE  = 4;
  localparam int DEB       = 8;
  localparam int PRESS_LAT = DEB + 3;
  localparam int REL_WAIT  = DEB + 6;
  localparam int PERIOD    = 60 * 60 * 70;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              vga_clk_en = 1'b0;
  logic              btn_ss = 1'b0;
  logic              btn_lr = 1'b0;
  logic [TIME_W-1:0] i_time;
  logic              cnt_up_pls;
  logic              tmr_rst_n;
  logic [TIME_W-1:0] o_disp_time;
  logic              o_running;
  logic              o_lap;
  sw_state_e         o_state;

  stopwatch_ctrl #(.PRESCALE(PRESCALE), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vga_clk_en  (vga_clk_en),
    .btn_ss      (btn_ss),
    .btn_lr      (btn_lr),
    .i_time      (i_time),
    .cnt_up_pls  (cnt_up_pls),
    .tmr_rst_n   (tmr_rst_n),
    .o_disp_time (o_disp_time),
    .o_running   (o_running),
    .o_lap       (o_lap),
    .o_state     (o_state)
  );

  // ---------------- clock / strobe ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) begin
    #1;
    cyc++;
    vga_clk_en = (cyc % 4 == 0);
  end

  // ---------------- timer model and monitors ----------------
  function automatic logic [TIME_W-1:0] pack_time(input int t);
    int tt, frac, s, m;
    tt   = t % PERIOD;
    frac = tt % 70;
    s    = (tt / 70) % 60;
    m    = (tt / 4200) % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            3'(frac / 10), 4'(frac % 10)};
  endfunction

  int        tmr_ticks = 0;
  int        strobe_total = 0;
  int        pls_total = 0;
  int        pls_no_en = 0;
  int        state_changes = 0;
  int        cur_low = 0;
  int        last_low = 0;
  int        low_runs = 0;
  sw_state_e prev_state = ST_IDLE;

  bit        m_run = 1'b0;

  assign i_time = pack_time(tmr_ticks);

  always @(negedge clk) begin
    if (!rst_n || !tmr_rst_n) tmr_ticks = 0;
    else if (cnt_up_pls)      tmr_ticks++;
    if (vga_clk_en && m_run) strobe_total++;
    if (cnt_up_pls) pls_total++;
    if (cnt_up_pls && !vga_clk_en) pls_no_en++;
    if (o_state != prev_state) begin
      state_changes++;
      prev_state = o_state;
    end
    if (!tmr_rst_n) begin
      cur_low++;
    end else if (cur_low != 0) begin
      last_low = cur_low;
      low_runs++;
      cur_low  = 0;
    end
  end

  // ---------------- reference model ----------------
  sw_state_e m_mode = ST_IDLE;
  bit        track = 1'b0;
  int        strobe_base = 0;
  int        lap_ticks = 0;
  int        exp_clears = 0;

  function automatic int run_str();
    return strobe_total - strobe_base;
  endfunction

  task automatic model_apply(input bit ss, input bit lr);
    if (ss) begin
      case (m_mode)
        ST_IDLE, ST_PAUSE: m_mode = ST_RUN;
        ST_RUN, ST_LAP:    m_mode = ST_PAUSE;
        default: ;
      endcase
    end else if (lr) begin
      case (m_mode)
        ST_RUN: begin
          lap_ticks = run_str() / PRESCALE;
          m_mode    = ST_LAP;
        end
        ST_LAP:   m_mode = ST_RUN;
        ST_PAUSE: begin
          m_mode      = ST_IDLE;
          strobe_base = strobe_total;
          exp_clears++;
        end
        default: ;
      endcase
    end
    m_run = track && ((m_mode == ST_RUN) || (m_mode == ST_LAP));
  endtask

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_step(input string tag);
    check({tag, "_state"}, 32'(o_state), 32'(m_mode));
    check({tag, "_running"}, 32'(o_running), 32'((m_mode == ST_RUN) || (m_mode == ST_LAP)));
    check({tag, "_lap"}, 32'(o_lap), 32'(m_mode == ST_LAP));
    check({tag, "_clear_count"}, 32'(low_runs), 32'(exp_clears));
    if (exp_clears > 0) check({tag, "_clear_len"}, 32'(last_low), 32'd2);
    if (track) begin
      check({tag, "_timer"}, 32'(tmr_ticks), 32'(run_str() / PRESCALE));
      check({tag, "_disp"}, 32'(o_disp_time),
            32'((m_mode == ST_LAP) ? pack_time(lap_ticks) : pack_time(run_str() / PRESCALE)));
    end
  endtask

  // ---------------- driver ----------------
  // With alignment the raw edge comes just before a strobe edge, so the
  // resulting state change lands halfway between two strobes.
  task automatic press(input bit ss, input bit lr, input bit do_align);
    int guard;
    if (do_align) begin
      guard = 0;
      do begin
        @(posedge clk); #2;
        guard++;
      end while (!vga_clk_en && guard < 8);
    end
    btn_ss = ss;
    btn_lr = lr;
    repeat (PRESS_LAT) @(posedge clk);
    #2;
    model_apply(ss, lr);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    repeat (REL_WAIT) @(posedge clk);
    #2;
  endtask

  task automatic wait_strobes(input int n);
    repeat (n * 4) @(posedge clk);
    #2;
  endtask

  typedef struct {
    bit        ss;
    bit        lr;
    int        hold;
    sw_state_e exp_state;
    bit        exp_running;
    bit        exp_lap;
  } step_t;

  step_t tbl[13];

  // ---------------- test ----------------
  initial begin
    int ch0;
    int guard;
    int clears0;
    bit found;

    tbl[0]  = '{1'b0, 1'b1, 3, ST_LAP,   1'b1, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 8, ST_PAUSE, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 5, ST_RUN,   1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 2, ST_PAUSE, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 0, ST_IDLE,  1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 0, ST_IDLE,  1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 6, ST_RUN,   1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 2, ST_LAP,   1'b1, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 7, ST_RUN,   1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8, ST_PAUSE, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 9, ST_RUN,   1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1, ST_PAUSE, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 3, ST_RUN,   1'b1, 1'b0};

    // Reset values.
    repeat (3) @(posedge clk);
    #2;
    check("rst_state", 32'(o_state), 32'(ST_IDLE));
    check("rst_running", 32'(o_running), 32'd0);
    check("rst_lap", 32'(o_lap), 32'd0);
    check("rst_tmr_rst_n", 32'(tmr_rst_n), 32'd1);
    check("rst_cnt_up", 32'(cnt_up_pls), 32'd0);
    check("rst_disp", 32'(o_disp_time), 32'd0);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    check("idle_state", 32'(o_state), 32'(ST_IDLE));
    check("idle_no_pulses", 32'(pls_total), 32'd0);

    // Bouncing start/stop: toggles every 3 clk, then settles high.
    ch0 = state_changes;
    for (int i = 0; i < 7; i++) begin
      btn_ss = (i % 2 == 0);
      repeat (3) @(posedge clk);
      #2;
    end
    check("bounce_no_early_press", 32'(state_changes - ch0), 32'd0);
    btn_ss = 1'b1;
    repeat (DEB + 4) @(posedge clk);
    #2;
    check("bounce_state", 32'(o_state), 32'(ST_RUN));
    check("bounce_running", 32'(o_running), 32'd1);
    btn_ss = 1'b0;
    repeat (REL_WAIT) @(posedge clk);
    #2;
    check("bounce_one_press", 32'(state_changes - ch0), 32'd1);
    m_mode = ST_RUN;

    // Pause, then clear; model timing starts from the clear.
    press(1'b1, 1'b0, 1'b1);
    check_step("pause1");
    track = 1'b1;
    press(1'b0, 1'b1, 1'b1);
    check_step("clear1");

    // 40 strobes in RUN give 10 count-up pulses: 00:00.10.
    press(1'b1, 1'b0, 1'b1);
    check_step("run1");
    guard = 0;
    found = 1'b0;
    while (!found && guard < 400) begin
      @(negedge clk); #1;
      guard++;
      if (run_str() >= 40) found = 1'b1;
    end
    check("run40_reached", 32'(run_str()), 32'd40);
    check("run40_ticks", 32'(tmr_ticks), 32'd10);
    check("run40_time", 32'(i_time), 32'h10);

    // Lap capture at 00:01.23 (93 ticks, captured after 375 strobes).
    guard = 0;
    found = 1'b0;
    while (!found && guard < 2000) begin
      @(posedge clk); #2;
      guard++;
      if (vga_clk_en && run_str() == 372) found = 1'b1;
    end
    check("lap_align_found", 32'(found), 32'd1);
    press(1'b0, 1'b1, 1'b0);
    check_step("lap1");
    check("lap_disp_0123", 32'(o_disp_time), 32'h0000A3);
    wait_strobes(10);
    check("lap_disp_frozen", 32'(o_disp_time), 32'h0000A3);
    check("lap_live_advanced", 32'(i_time == 23'h0000A3), 32'd0);
    check_step("lap1_hold");
    press(1'b0, 1'b1, 1'b1);
    check_step("lap1_exit");
    check("live_disp", 32'(o_disp_time), 32'(i_time));

    // Table-driven press sequence.
    for (int i = 0; i < 13; i++) begin
      press(tbl[i].ss, tbl[i].lr, 1'b1);
      check($sformatf("tbl%0d_state", i), 32'(o_state), 32'(tbl[i].exp_state));
      check($sformatf("tbl%0d_running", i), 32'(o_running), 32'(tbl[i].exp_running));
      check($sformatf("tbl%0d_lap", i), 32'(o_lap), 32'(tbl[i].exp_lap));
      wait_strobes(tbl[i].hold);
      check_step($sformatf("tbl%0d", i));
    end

    // Randomized presses against the model.
    for (int i = 0; i < 16; i++) begin
      int r;
      r = $urandom_range(0, 3);
      press(r == 0 || r == 2 || r == 3, r == 1 || r == 2, 1'b1);
      wait_strobes($urandom_range(0, 6));
      check_step($sformatf("rnd%0d", i));
    end

    // Reset mid-RUN with start/stop held through reset release.
    if (m_mode == ST_LAP) press(1'b0, 1'b1, 1'b1);
    else if (m_mode != ST_RUN) press(1'b1, 1'b0, 1'b1);
    check_step("pre_reset_run");
    guard = 0;
    do begin
      @(posedge clk); #2;
      guard++;
    end while (!vga_clk_en && guard < 8);
    clears0 = low_runs;
    btn_ss  = 1'b1;
    rst_n   = 1'b0;
    #1;
    check("midrst_state", 32'(o_state), 32'(ST_IDLE));
    check("midrst_running", 32'(o_running), 32'd0);
    check("midrst_lap", 32'(o_lap), 32'd0);
    check("midrst_cnt_up", 32'(cnt_up_pls), 32'd0);
    check("midrst_tmr_rst_n", 32'(tmr_rst_n), 32'd1);
    m_mode      = ST_IDLE;
    m_run       = 1'b0;
    strobe_base = strobe_total;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (DEB) @(posedge clk);
    #2;
    check("held_no_early_press", 32'(o_state), 32'(ST_IDLE));
    repeat (4) @(posedge clk);
    #2;
    check("held_press_after_debounce", 32'(o_state), 32'(ST_RUN));
    check("midrst_no_tmr_pulse", 32'(low_runs), 32'(clears0));
    btn_ss = 1'b0;
    repeat (REL_WAIT) @(posedge clk);
    #2;

    check("pulse_only_with_strobe", 32'(pls_no_en), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Overall time limit.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
